cond_unit: RTL and testbench

COND_UNIT -- requirements
Module: cond_unit

---
 rtl/cpu_pkg.sv | 17 +
 rtl/cond_eval.sv | 41 ++++
 rtl/cond_unit.sv | 91 +++++++++
 tb/tb_cond_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ARM condition codes and flag bit positions.
// Flags use {C,N,V,Z} order, so bit 3 is C.
package cpu_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_e;

  localparam int C_BIT = 3;
  localparam int N_BIT = 2;
  localparam int V_BIT = 1;
  localparam int Z_BIT = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition check of Cond against the registered flags.
// The NV encoding (and any unknown code) evaluates false.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic c_s, n_s, v_s, z_s;

  assign c_s = Flags[C_BIT];
  assign n_s = Flags[N_BIT];
  assign v_s = Flags[V_BIT];
  assign z_s = Flags[Z_BIT];

  // condition table lookup
  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      EQ:      CondEx = z_s;
      NE:      CondEx = ~z_s;
      CS:      CondEx = c_s;
      CC:      CondEx = ~c_s;
      MI:      CondEx = n_s;
      PL:      CondEx = ~n_s;
      VS:      CondEx = v_s;
      VC:      CondEx = ~v_s;
      HI:      CondEx = c_s & ~z_s;
      LS:      CondEx = ~(c_s & ~z_s);
      GE:      CondEx = ~(n_s ^ v_s);
      LT:      CondEx = n_s ^ v_s;
      GT:      CondEx = ~z_s & ~(n_s ^ v_s);
      LE:      CondEx = ~(~z_s & ~(n_s ^ v_s));
      AL:      CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execute stage: holds the flag register and the registered,
// condition-qualified write requests handed to the next stage.
module cond_unit
  import cpu_pkg::*;
#(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       flush,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags,
  output logic       CondEx,
  output logic       Undef
);

  logic [3:0] flags_r;
  logic [3:0] flags_nxt_s;
  logic       exe_s;
  logic       pcsrc_r;
  logic       regwrite_r;
  logic       memwrite_r;
  logic       undef_r;

  cond_eval u_cond_eval (
    .Cond   (Cond),
    .Flags  (flags_r),
    .CondEx (CondEx)
  );

  assign exe_s = CondEx & en & ~flush;

  // merge ALU flags into the register, N/Z and C/V enabled independently
  always_comb begin
    flags_nxt_s = flags_r;
    if (exe_s && FlagW[1]) begin
      flags_nxt_s[N_BIT] = ALUFlags[N_BIT];
      flags_nxt_s[Z_BIT] = ALUFlags[Z_BIT];
    end else begin
      flags_nxt_s[N_BIT] = flags_r[N_BIT];
      flags_nxt_s[Z_BIT] = flags_r[Z_BIT];
    end
    if (exe_s && FlagW[0]) begin
      flags_nxt_s[C_BIT] = ALUFlags[C_BIT];
      flags_nxt_s[V_BIT] = ALUFlags[V_BIT];
    end else begin
      flags_nxt_s[C_BIT] = flags_r[C_BIT];
      flags_nxt_s[V_BIT] = flags_r[V_BIT];
    end
  end

  // flag and output registers; reset wins over a stall
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_r    <= FLAGS_RST;
      pcsrc_r    <= 1'b0;
      regwrite_r <= 1'b0;
      memwrite_r <= 1'b0;
      undef_r    <= 1'b0;
    end else if (en) begin
      flags_r    <= flags_nxt_s;
      pcsrc_r    <= PCS & exe_s;
      regwrite_r <= RegW & ~NoWrite & exe_s;
      memwrite_r <= MemW & exe_s;
      undef_r    <= (Cond == NV) & ~flush;
    end else begin
      flags_r    <= flags_r;
      pcsrc_r    <= pcsrc_r;
      regwrite_r <= regwrite_r;
      memwrite_r <= memwrite_r;
      undef_r    <= undef_r;
    end
  end

  assign Flags    = flags_r;
  assign PCSrc    = pcsrc_r;
  assign RegWrite = regwrite_r;
  assign MemWrite = memwrite_r;
  assign Undef    = undef_r;

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: a per-flag behavioural model checked on
// every falling edge, plus directed vectors with literal expectations.
module tb_cond_unit;

  logic       clk = 1'b0;
  logic       reset, en, flush;
  logic [3:0] Cond, ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite;
  logic       PCSrc, RegWrite, MemWrite, CondEx, Undef;
  logic [3:0] Flags;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // model state: individual flags and expected registered outputs
  bit mc, mn, mv, mz;
  bit m_pcsrc, m_regw, m_memw, m_undef;

  cond_unit #(.FLAGS_RST(4'b0000)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .Cond(Cond),
    .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .NoWrite(NoWrite), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .Flags(Flags), .CondEx(CondEx), .Undef(Undef)
  );

  always #5 clk = ~clk;

  // ARM pairs conditions: even code tests a predicate, the odd code its inverse
  function automatic bit mcond(input int code, input bit c, n, v, z);
    bit base;
    if (code == 14) return 1'b1;
    if (code == 15) return 1'b0;
    case (code / 2)
      0:       base = z;
      1:       base = c;
      2:       base = n;
      3:       base = v;
      4:       base = c && !z;
      5:       base = (n == v);
      default: base = !z && (n == v);
    endcase
    return (code % 2 == 1) ? !base : base;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      {mc, mn, mv, mz} <= 4'b0000;
      m_pcsrc <= 1'b0; m_regw <= 1'b0; m_memw <= 1'b0; m_undef <= 1'b0;
    end else if (en) begin
      m_pcsrc <= PCS && mcond(int'(Cond), mc, mn, mv, mz) && !flush;
      m_regw  <= RegW && !NoWrite && mcond(int'(Cond), mc, mn, mv, mz) && !flush;
      m_memw  <= MemW && mcond(int'(Cond), mc, mn, mv, mz) && !flush;
      m_undef <= (Cond == 4'd15) && !flush;
      if (mcond(int'(Cond), mc, mn, mv, mz) && !flush && FlagW[1]) begin
        mn <= ALUFlags[2];
        mz <= ALUFlags[0];
      end
      if (mcond(int'(Cond), mc, mn, mv, mz) && !flush && FlagW[0]) begin
        mc <= ALUFlags[3];
        mv <= ALUFlags[1];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_Flags", Flags, {mc, mn, mv, mz});
      chk("model_PCSrc", {3'b000, PCSrc}, {3'b000, m_pcsrc});
      chk("model_RegWrite", {3'b000, RegWrite}, {3'b000, m_regw});
      chk("model_MemWrite", {3'b000, MemWrite}, {3'b000, m_memw});
      chk("model_Undef", {3'b000, Undef}, {3'b000, m_undef});
      chk("model_CondEx", {3'b000, CondEx}, {3'b000, mcond(int'(Cond), mc, mn, mv, mz)});
    end
  end

  task automatic drive(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] af,
                       input logic pcs_i, input logic regw_i, input logic memw_i,
                       input logic nw_i, input logic en_i, input logic fl_i);
    Cond = c; FlagW = fw; ALUFlags = af; PCS = pcs_i; RegW = regw_i;
    MemW = memw_i; NoWrite = nw_i; en = en_i; flush = fl_i;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    drive(4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    chk_on = 1'b1;
    chk("rst_Flags", Flags, 4'b0000);
    chk("rst_Undef", {3'b000, Undef}, 4'b0000);

    // AL writes all flags; EQ then sees Z=1
    drive(4'b1110, 2'b11, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("al_Flags", Flags, 4'b0101);
    drive(4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 chk("eq_CondEx", {3'b000, CondEx}, 4'b0001);
    tick();

    // failed EQ: no write, no flag update
    do_reset();
    drive(4'b0000, 2'b11, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 chk("eqfail_CondEx", {3'b000, CondEx}, 4'b0000);
    tick();
    chk("eqfail_RegWrite", {3'b000, RegWrite}, 4'b0000);
    chk("eqfail_Flags", Flags, 4'b0000);

    // N/Z only
    drive(4'b1110, 2'b10, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("nz_only_Flags", Flags, 4'b0101);

    // MemWrite set, then stall holds, then flush clears
    drive(4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk("mem_MemWrite", {3'b000, MemWrite}, 4'b0001);
    drive(4'b1110, 2'b11, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("stall_MemWrite", {3'b000, MemWrite}, 4'b0001);
    chk("stall_Flags", Flags, 4'b0101);
    drive(4'b1110, 2'b11, 4'b1010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    chk("flush_MemWrite", {3'b000, MemWrite}, 4'b0000);
    chk("flush_Flags", Flags, 4'b0101);

    // NV: never executes, Undef pulses one cycle
    drive(4'b1111, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 chk("nv_CondEx", {3'b000, CondEx}, 4'b0000);
    tick();
    chk("nv_RegWrite", {3'b000, RegWrite}, 4'b0000);
    chk("nv_Undef", {3'b000, Undef}, 4'b0001);
    drive(4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("nv_Undef_end", {3'b000, Undef}, 4'b0000);

    // signed compares at three flag settings
    drive(4'b1110, 2'b11, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("ge_setup_Flags", Flags, 4'b0100);
    drive(4'b1010, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("ge_0100", {3'b000, CondEx}, 4'b0000);
    Cond = 4'b1011; #1 chk("lt_0100", {3'b000, CondEx}, 4'b0001);
    Cond = 4'b1100; #1 chk("gt_0100", {3'b000, CondEx}, 4'b0000);
    Cond = 4'b1101; #1 chk("le_0100", {3'b000, CondEx}, 4'b0001);
    tick();
    drive(4'b1110, 2'b11, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(4'b1010, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("ge_0110", {3'b000, CondEx}, 4'b0001);
    Cond = 4'b1100; #1 chk("gt_0110", {3'b000, CondEx}, 4'b0001);
    tick();
    drive(4'b1110, 2'b11, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(4'b1100, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("gt_0111", {3'b000, CondEx}, 4'b0000);
    Cond = 4'b1101; #1 chk("le_0111", {3'b000, CondEx}, 4'b0001);
    tick();

    // reset during a stall clears everything; EQ then sees reset flags
    drive(4'b1110, 2'b11, 4'b1101, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("pre_Flags", Flags, 4'b1101);
    chk("pre_PCSrc", {3'b000, PCSrc}, 4'b0001);
    reset = 1'b1;
    en = 1'b0;
    tick();
    reset = 1'b0;
    chk("stallrst_Flags", Flags, 4'b0000);
    chk("stallrst_RegWrite", {3'b000, RegWrite}, 4'b0000);
    drive(4'b0000, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 chk("postrst_CondEx", {3'b000, CondEx}, 4'b0000);
    tick();

    // sweep every condition over every flag pattern against the model
    for (int f = 0; f < 16; f++) begin
      drive(4'b1110, 2'b11, 4'(f), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      for (int cc = 0; cc < 16; cc++) begin
        drive(4'(cc), 2'b00, 4'(15 - f), cc[0], 1'b1, cc[1], cc[2] & cc[3],
              1'b1, (cc == 5) ? 1'b1 : 1'b0);
        tick();
      end
    end

    // partial flag update through a conditional instruction (CS)
    drive(4'b0010, 2'b01, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("cs_cv_Flags", Flags, 4'b0101);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
